// File: rtl/tmpl_match_ctrl.sv
// Template-match scheduler: one SAD candidate per frame over a raster grid, best offset reported on oDONE.
// Latency: pixel to SAD in 2 cycles; no backpressure (stream-driven). Optional oHIT overlay under TMPL_OVERLAY_EN.
module tmpl_match_ctrl #(
  parameter int TPL_W = 128,
  parameter int TPL_H = 128,
  parameter int STEP  = 64,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [12:0] iX,
  input  logic [12:0] iY,
  input  logic [9:0]  iGRAY,
  output logic [12:0] oTX,
  output logic [12:0] oTY,
  input  logic [10:0] iTVAL,
  output logic [12:0] oCAND_X,
  output logic [12:0] oCAND_Y,
  output logic [12:0] oBEST_X,
  output logic [12:0] oBEST_Y,
  output logic [23:0] oBEST_SAD,
  output logic        oBUSY,
  output logic        oDONE
`ifdef TMPL_OVERLAY_EN
  ,
  output logic        oHIT
`endif
);

  localparam int OX_MAX = IMG_W - TPL_W;
  localparam int OY_MAX = IMG_H - TPL_H;
  localparam int NPIX   = TPL_W * TPL_H;

  typedef enum logic [2:0] {S_SYNC, S_ARM, S_ACC, S_EVAL, S_DONE} state_t;

  state_t      state;
  logic        fval_q;
  logic        s1_vld;
  logic        s1_win;
  logic [7:0]  gray8;
  logic [23:0] sad;
  logic [15:0] pcnt;
  logic [23:0] run_sad;
  logic [12:0] run_x;
  logic [12:0] run_y;

  // Negative offsets wrap to large unsigned values and fail the window test.
  logic [12:0] dx, dy;
  logic        in_win;
  assign dx     = iX - oCAND_X;
  assign dy     = iY - oCAND_Y;
  assign in_win = ({1'b0, dx} < 14'(TPL_W)) && ({1'b0, dy} < 14'(TPL_H));

  logic [7:0]  tval8;
  logic [7:0]  adiff;
  logic        acc_en;
  logic [23:0] sad_nxt;
  logic [15:0] pcnt_nxt;
  assign tval8  = iTVAL[7:0];
  assign adiff  = (gray8 >= tval8) ? (gray8 - tval8) : (tval8 - gray8);
  assign acc_en = s1_vld && s1_win && ((state == S_ACC) || (state == S_EVAL));

  always_comb begin
    sad_nxt  = sad;
    pcnt_nxt = pcnt;
    if (acc_en) begin
      sad_nxt  = sad + {16'd0, adiff};
      pcnt_nxt = pcnt + 16'd1;
    end
  end

  logic tval_unused;
  assign tval_unused = ^{iTVAL[10:8], iGRAY[1:0]};

  logic x_wrap, y_last, last_cand, better;
  assign x_wrap    = (int'(oCAND_X) + STEP) > OX_MAX;
  assign y_last    = (int'(oCAND_Y) + STEP) > OY_MAX;
  assign last_cand = x_wrap && y_last;
  assign better    = sad_nxt < run_sad;

`ifdef TMPL_OVERLAY_EN
  logic        best_vld;
  logic [12:0] hx, hy;
  logic        hit_c;
  assign hx    = iX - oBEST_X;
  assign hy    = iY - oBEST_Y;
  assign hit_c = best_vld && ({1'b0, hx} < 14'(TPL_W)) && ({1'b0, hy} < 14'(TPL_H));
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= S_SYNC;
      fval_q    <= 1'b0;
      s1_vld    <= 1'b0;
      s1_win    <= 1'b0;
      gray8     <= '0;
      oTX       <= '0;
      oTY       <= '0;
      sad       <= '0;
      pcnt      <= '0;
      run_sad   <= 24'hFFFFFF;
      run_x     <= '0;
      run_y     <= '0;
      oCAND_X   <= '0;
      oCAND_Y   <= '0;
      oBEST_X   <= '0;
      oBEST_Y   <= '0;
      oBEST_SAD <= 24'hFFFFFF;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
`ifdef TMPL_OVERLAY_EN
      best_vld  <= 1'b0;
      oHIT      <= 1'b0;
`endif
    end else begin
      fval_q <= iFVAL;
      s1_vld <= iDVAL;
      if (iDVAL) begin
        oTX    <= dx;
        oTY    <= dy;
        gray8  <= iGRAY[9:2];
        s1_win <= in_win;
`ifdef TMPL_OVERLAY_EN
        oHIT   <= hit_c;
`endif
      end
      if (acc_en) begin
        sad  <= sad_nxt;
        pcnt <= pcnt_nxt;
      end
      oDONE <= 1'b0;

      case (state)
        S_SYNC: if (!iFVAL) state <= S_ARM;
        S_ARM: begin
          if (iFVAL && !fval_q) begin
            sad   <= '0;
            pcnt  <= '0;
            oBUSY <= 1'b1;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          if (!iFVAL) begin
            oBUSY <= 1'b0;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          // Short or empty frames retry the same candidate.
          if (pcnt_nxt == 16'(NPIX)) begin
            if (better) begin
              run_sad <= sad_nxt;
              run_x   <= oCAND_X;
              run_y   <= oCAND_Y;
            end
            if (last_cand) begin
              oBEST_X   <= better ? oCAND_X : run_x;
              oBEST_Y   <= better ? oCAND_Y : run_y;
              oBEST_SAD <= better ? sad_nxt : run_sad;
              oDONE     <= 1'b1;
              state     <= S_DONE;
            end else begin
              if (x_wrap) begin
                oCAND_X <= '0;
                oCAND_Y <= oCAND_Y + 13'(STEP);
              end else begin
                oCAND_X <= oCAND_X + 13'(STEP);
              end
              state <= S_ARM;
            end
          end else begin
            state <= S_ARM;
          end
        end
        S_DONE: begin
          run_sad  <= 24'hFFFFFF;
          run_x    <= '0;
          run_y    <= '0;
          oCAND_X  <= '0;
          oCAND_Y  <= '0;
`ifdef TMPL_OVERLAY_EN
          best_vld <= 1'b1;
`endif
          state    <= S_ARM;
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: doc/tmpl_match_ctrl.md
# tmpl_match_ctrl

- Schedules template matching of the 16x16-cell template lookup against the live camera stream.
- Each frame, it compares the template at one candidate offset and accumulates the sum of absolute differences (SAD) over the template window.
- It steps the offset across a raster grid, one candidate per frame, and reports the best-matching offset after the last grid point.
- It sits between the grey-scale pixel stream and the template lookup, and drives the lookup's coordinate inputs.

## Interface
Parameters:
- TPL_W, 128, template width in pixels
- TPL_H, 128, template height in pixels
- STEP, 64, candidate grid step in pixels (both axes)
- IMG_W, 640, active image width
- IMG_H, 480, active image height

Ports:
- iCLK  in  1  pixel clock; single clock domain
- iRST  in  1  synchronous reset, active-high
- iFVAL  in  1  frame valid
- iDVAL  in  1  pixel valid
- iX  in  13  pixel column
- iY  in  13  pixel row
- iGRAY  in  10  pixel luminance
- oTX  out  13  template-relative column, to lookup
- oTY  out  13  template-relative row, to lookup
- iTVAL  in  11  lookup result; combinational from oTX/oTY
- oCAND_X  out  13  current candidate offset, column
- oCAND_Y  out  13  current candidate offset, row
- oBEST_X  out  13  best offset of last completed search, column
- oBEST_Y  out  13  best offset of last completed search, row
- oBEST_SAD  out  24  SAD at best offset
- oBUSY  out  1  high while accumulating a frame
- oDONE  out  1  one-cycle pulse when a search completes

## Operation
**Candidate grid**
- OX steps 0, STEP, … while OX ≤ IMG_W−TPL_W.
- OY steps the same way while OY ≤ IMG_H−TPL_H.
- Order is raster: OX advances first, then OY.
- Defaults give 9×6 = 54 candidates.

**Stage 1 (when iDVAL=1)**
- oTX←iX−OX, oTY←iY−OY.
- Register iGRAY[9:2].
- Register in-window flag: iX−OX < TPL_W and iY−OY < TPL_H, evaluated unsigned, so negatives fail.

**Stage 2**
- If the stage-1 valid and in-window flags are set: SAD += |gray8 − iTVAL[7:0]| and PCNT += 1.
- SAD is 24-bit; maximum is 128·128·255 < 2^24, so no overflow.
- PCNT is 16-bit.

**State machine**
- SYNC: wait for iFVAL=0. Entered after reset; discards any partial frame.
- ARM: on iFVAL rising edge, clear SAD/PCNT → ACC.
- ACC: accumulate. On iFVAL falling edge → EVAL.
- EVAL (one cycle; the stage-2 pixel in flight is included):
  - If PCNT == TPL_W·TPL_H:
    - if SAD < run_best, store SAD and offset into the running best;
    - advance the candidate;
    - after the last candidate → DONE, otherwise → ARM.
  - If PCNT differs (short frame): keep the same candidate and go → ARM.
- DONE (one cycle):
  - copy the running best to oBEST_*;
  - pulse oDONE;
  - reset the running best to SAD 24'hFFFFFF and offset (0,0);
  - reset the candidate to (0,0);
  - → ARM.

**Tie-break**
- The comparison is strict less-than, so the earliest candidate in raster order wins a tie.

**Reset values**
- oTX, oTY, oCAND_X, oCAND_Y, oBEST_X, oBEST_Y: 0.
- oBEST_SAD: 24'hFFFFFF.
- oBUSY, oDONE: 0.
- Internal SAD, PCNT and the running best are also cleared.

## Timing
- oTX/oTY are registered one cycle after their iDVAL pixel.
- iTVAL is sampled in the cycle after oTX/oTY update.
- Total accumulation latency is 2 cycles from pixel to SAD.
- oBUSY is high exactly in ACC.
- oDONE rises one cycle after the EVAL of the last candidate.
- oBEST_* change only in the DONE cycle.
- iFVAL rising and falling in consecutive cycles gives an empty frame: PCNT = 0, rejected.
- iRST mid-frame: all state clears → SYNC; no partial result reaches oBEST_*.

## Configuration
**TMPL_OVERLAY_EN defined**
- Adds output oHIT (1 bit), registered and aligned with oTX/oTY.
- oHIT is high when the stage-1 pixel lies inside the box [oBEST_X, oBEST_X+TPL_W) × [oBEST_Y, oBEST_Y+TPL_H).
- oHIT is 0 until the first oDONE and 0 after reset.

**TMPL_OVERLAY_EN not defined**
- oHIT port and logic are absent.
- All other behaviour is identical.

## Test plan
1. Reset held 3 cycles with iFVAL=1, then released mid-frame → stays in SYNC and ignores that frame; oBUSY=0 until the next iFVAL rise.
2. Full frames with iGRAY=1020 (gray8=255) and lookup constant 255 → every SAD=0; after 54 frames oDONE pulses once with oBEST=(0,0) and SAD=0 (tie-break).
3. Lookup returns 0 everywhere, image gray8=255 except a 128×128 block of gray8=0 at (192,128) → after 54 frames oBEST=(192,128), oBEST_SAD=0.
4. Frame 5 cut short (iFVAL falls at row 100) → oCAND_X/Y unchanged after that frame; search completes after 55 frames.
5. iDVAL toggling 1/0 every cycle within a frame → same SAD as a contiguous stream; PCNT=16384 per accepted frame.
6. With TMPL_OVERLAY_EN and best=(192,128): pixel (192,128) → oHIT=1 one cycle later; pixel (320,128) → oHIT=0.
